torreta_disparo_ctrl: RTL
=========================

# torreta_disparo_ctrl

Parametrised fire-control unit for the next-generation turret. It sits between the sonar measurement path and the firing/reload actuators. It takes one registered distance per completed measurement, compares it against a run-time threshold, and, depending on fire mode, runs single, burst or automatic fire sequences with timed shot and reload phases. It also owns the saturating ammunition counter and reports a one-cycle completion pulse back to the sweep controller.

## Interface
Parameters:
- DIST_BITS, 12, width of distance and threshold (binary, cm)
- MUN_BITS, 4, width of ammo counter
- MAX_MUNICAO, 9, ammo saturation value (must be < 2^MUN_BITS)
- RAJADA, 3, shots per burst (≥1)
- CICLOS_DISPARO, 25_000_000, cycles acionar_motor stays high per shot
- CICLOS_RECARGA, 50_000_000, cycles of reload phase per shot

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low
- habilitar  in  1  level; enables evaluation/firing
- medida_valida  in  1  one-cycle pulse, distancia valid
- distancia  in  DIST_BITS  measured distance; 0 = timeout/invalid
- limiar  in  DIST_BITS  threat threshold
- modo  in  2  00 single, 01 burst, 10 auto, 11 safe
- soma_municao  in  1  one-cycle pulse, add one round
- acionar_motor  out  1  high during shot phase
- recarregando  out  1  high during reload phase
- ameaca_detectada  out  1  result of last evaluation
- fim_ciclo  out  1  one-cycle pulse, evaluation/sequence finished
- contagem_municao  out  MUN_BITS  current ammo
- sem_municao  out  1  contagem_municao == 0
- cheio  out  1  contagem_municao == MAX_MUNICAO
- db_estado  out  4  state code

## Operation
- States/codes: INICIAL 0, ESPERA 1, AVALIA 2, DISPARA 3, RECARREGA 4; any illegal state shows F and goes to INICIAL.
- INICIAL: when habilitar=1, go to ESPERA.
- ESPERA: on medida_valida, register distancia into dist_reg and go to AVALIA. When habilitar=0, go to INICIAL. medida_valida is ignored in every other state.
- AVALIA, single cycle:
  - ameaca = (dist_reg != 0) && (dist_reg < limiar); this value is latched into ameaca_detectada.
  - Fire when ameaca, ammo>0, modo!=11, and (modo==10 or armado). The remaining-shot counter is loaded with RAJADA if modo==01, otherwise 1. Go to DISPARA and clear armado.
  - Otherwise pulse fim_ciclo and go to ESPERA. If ameaca=0, set armado.
- DISPARA: acionar_motor=1 for CICLOS_DISPARO cycles. On the last cycle, decrement ammo and the remaining-shot count, then go to RECARREGA.
- RECARREGA: recarregando=1 for CICLOS_RECARGA cycles. On the last cycle:
  - If remaining>0, ammo>0, habilitar=1 and modo!=11, go to DISPARA.
  - Otherwise pulse fim_ciclo and go to ESPERA.
- habilitar=0 or modo=11 mid-sequence never truncates the current shot or reload. It only cancels the shots still remaining.
- Ammo counter runs independently of state, including in INICIAL:
  - soma_municao increments it, saturating at MAX_MUNICAO.
  - Decrement never underflows.
  - Simultaneous increment and decrement leaves the count unchanged, including at full.
- armado is set on reset. Auto mode ignores armado.

## Timing
- Reset values: state INICIAL, all outputs 0 except sem_municao=1 and db_estado=0; contagem 0; armado=1.
- medida_valida at cycle t: AVALIA at t+1; acionar_motor rises at t+2 (registered state decode).
- The shot lasts exactly CICLOS_DISPARO cycles. recarregando follows immediately for exactly CICLOS_RECARGA cycles, with no gap.
- contagem_municao shows the decrement in the first RECARREGA cycle.
- Burst inter-shot period = CICLOS_DISPARO + CICLOS_RECARGA.
- fim_ciclo is combinational from state and timer-end. It is exactly one cycle wide.
- Reset asserted mid-operation: all registers return to reset values immediately; the shot is lost and ammo is cleared to 0.

## Structure
- Shared package torreta_pkg holds the state codes and the mode constants (MODO_UNICO, MODO_RAJADA, MODO_AUTO, MODO_SEGURO).
- One sub-module, contador_m: a parametrised modulo-M cycle counter with zera/conta inputs and a fim output. Two instances are used, one for shot timing and one for reload timing.
- Ammo counter, burst counter, armado flag and FSM stay inline.

## Test plan
All scenarios use CICLOS_DISPARO=4, CICLOS_RECARGA=6, RAJADA=3, MAX_MUNICAO=9.
- 12 soma_municao pulses → contagem ends at 9, cheio=1. A simultaneous add+shot at 9 leaves contagem at 9, not 10.
- Single mode, ammo 5, limiar 100, distancia 50 → acionar_motor high 4 cycles from t+2, recarregando 6 cycles, contagem 4, one fim_ciclo. A repeat at distancia 50 gives no shot; after distancia 200 then 50, it fires again.
- Burst mode, ammo 2, threat → two shots (period 10 cycles), contagem 0, sem_municao=1, fim_ciclo after the second reload.
- Auto mode, ammo 3, three consecutive threat measurements → three shots. distancia=0 → ameaca_detectada=0 and no shot.
- Burst in progress; modo→11 during the first shot → the first shot and reload complete, no second shot, contagem decremented by 1.
- reset low during DISPARA → acionar_motor=0 immediately, db_estado=0, contagem=0, armado=1.

Source files
------------

// File: rtl/torreta_pkg.sv
// Shared definitions for the turret fire-control unit: FSM state codes and
// fire-mode encodings used by the controller and its bench.
package torreta_pkg;

    typedef enum logic [2:0] {
        INICIAL   = 3'd0,
        ESPERA    = 3'd1,
        AVALIA    = 3'd2,
        DISPARA   = 3'd3,
        RECARREGA = 3'd4
    } estado_t;

    localparam logic [1:0] MODO_UNICO  = 2'b00;
    localparam logic [1:0] MODO_RAJADA = 2'b01;
    localparam logic [1:0] MODO_AUTO   = 2'b10;
    localparam logic [1:0] MODO_SEGURO = 2'b11;

    localparam logic [3:0] ESTADO_ILEGAL = 4'hF;

endpackage

// File: rtl/torreta_disparo_ctrl_contador_m.sv
// Modulo-M cycle counter; fim flags the last counted cycle (count M-1 while
// conta is high) so the owner can act on the same edge the count wraps.
module contador_m #(
    parameter int M = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (zera) begin
            q <= '0;
        end else if (conta) begin
            q <= (q == ULTIMO) ? '0 : q + 1'b1;
        end
    end

    assign fim = conta && (q == ULTIMO);

endmodule

// File: rtl/torreta_disparo_ctrl.sv
// Fire-control FSM: evaluates each distance against the threshold and runs
// timed shot/reload sequences in single, burst or auto mode, owning ammo.
module torreta_disparo_ctrl
    import torreta_pkg::*;
#(
    parameter int DIST_BITS      = 12,
    parameter int MUN_BITS       = 4,
    parameter int MAX_MUNICAO    = 9,
    parameter int RAJADA         = 3,
    parameter int CICLOS_DISPARO = 25_000_000,
    parameter int CICLOS_RECARGA = 50_000_000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 habilitar,
    input  logic                 medida_valida,
    input  logic [DIST_BITS-1:0] distancia,
    input  logic [DIST_BITS-1:0] limiar,
    input  logic [1:0]           modo,
    input  logic                 soma_municao,
    output logic                 acionar_motor,
    output logic                 recarregando,
    output logic                 ameaca_detectada,
    output logic                 fim_ciclo,
    output logic [MUN_BITS-1:0]  contagem_municao,
    output logic                 sem_municao,
    output logic                 cheio,
    output logic [3:0]           db_estado
);

    localparam int RB = $clog2(RAJADA + 1);
    localparam logic [MUN_BITS-1:0] MUN_MAX = MUN_BITS'(MAX_MUNICAO);

    estado_t              estado;
    logic [DIST_BITS-1:0] dist_reg;
    logic                 armado;
    logic [RB-1:0]        restantes;

    logic fim_disparo;
    logic fim_recarga;
    logic ameaca;
    logic dispara_ok;
    logic continua;

    contador_m #(.M(CICLOS_DISPARO)) u_tempo_disparo (
        .clock (clock),
        .reset (reset),
        .zera  (estado != DISPARA),
        .conta (estado == DISPARA),
        .fim   (fim_disparo)
    );

    contador_m #(.M(CICLOS_RECARGA)) u_tempo_recarga (
        .clock (clock),
        .reset (reset),
        .zera  (estado != RECARREGA),
        .conta (estado == RECARREGA),
        .fim   (fim_recarga)
    );

    assign ameaca     = (dist_reg != '0) && (dist_reg < limiar);
    assign dispara_ok = ameaca && (contagem_municao != '0) && (modo != MODO_SEGURO)
                        && ((modo == MODO_AUTO) || armado);
    // restantes and ammo are already decremented when the reload ends
    assign continua   = (restantes != '0) && (contagem_municao != '0)
                        && habilitar && (modo != MODO_SEGURO);

    assign fim_ciclo = ((estado == AVALIA) && !dispara_ok)
                     || ((estado == RECARREGA) && fim_recarga && !continua);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado           <= INICIAL;
            dist_reg         <= '0;
            armado           <= 1'b1;
            restantes        <= '0;
            ameaca_detectada <= 1'b0;
            acionar_motor    <= 1'b0;
            recarregando     <= 1'b0;
        end else begin
            case (estado)
                INICIAL: begin
                    if (habilitar) estado <= ESPERA;
                end
                ESPERA: begin
                    if (!habilitar) begin
                        estado <= INICIAL;
                    end else if (medida_valida) begin
                        dist_reg <= distancia;
                        estado   <= AVALIA;
                    end
                end
                AVALIA: begin
                    ameaca_detectada <= ameaca;
                    if (dispara_ok) begin
                        restantes     <= (modo == MODO_RAJADA) ? RB'(RAJADA) : RB'(1);
                        armado        <= 1'b0;
                        acionar_motor <= 1'b1;
                        estado        <= DISPARA;
                    end else begin
                        if (!ameaca) armado <= 1'b1;
                        estado <= ESPERA;
                    end
                end
                DISPARA: begin
                    if (fim_disparo) begin
                        if (restantes != '0) restantes <= restantes - 1'b1;
                        acionar_motor <= 1'b0;
                        recarregando  <= 1'b1;
                        estado        <= RECARREGA;
                    end
                end
                RECARREGA: begin
                    if (fim_recarga) begin
                        recarregando <= 1'b0;
                        if (continua) begin
                            acionar_motor <= 1'b1;
                            estado        <= DISPARA;
                        end else begin
                            estado <= ESPERA;
                        end
                    end
                end
                default: begin
                    acionar_motor <= 1'b0;
                    recarregando  <= 1'b0;
                    estado        <= INICIAL;
                end
            endcase
        end
    end

    // Add and spend in the same cycle cancel out, even at saturation
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem_municao <= '0;
        end else if (soma_municao && !fim_disparo) begin
            if (contagem_municao < MUN_MAX) contagem_municao <= contagem_municao + 1'b1;
        end else if (fim_disparo && !soma_municao) begin
            if (contagem_municao != '0) contagem_municao <= contagem_municao - 1'b1;
        end
    end

    assign sem_municao = (contagem_municao == '0);
    assign cheio       = (contagem_municao == MUN_MAX);

    always_comb begin
        db_estado = ESTADO_ILEGAL;
        case (estado)
            INICIAL, ESPERA, AVALIA, DISPARA, RECARREGA: db_estado = {1'b0, estado};
            default: db_estado = ESTADO_ILEGAL;
        endcase
    end

endmodule
